arm_fetch_unit: RTL and testbench



---
 rtl/arm_pkg.sv | 16 +
 rtl/arm_fetch_fifo.sv | 72 +++++++
 rtl/arm_fetch_unit.sv | 85 ++++++++
 tb/tb_arm_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM32 fetch stage.
// Word geometry, the fetch buffer entry and the decode-side NOP.
package arm_pkg;

    localparam int ARCH       = 32;
    localparam int WORD_BYTES = 4;

    // MOV r0, r0: inserted by decode when it needs a bubble.
    localparam logic [ARCH-1:0] NOP = 32'hE1A0_0000;

    typedef struct packed {
        logic [ARCH-1:0] ins;
        logic [ARCH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t with flush.
// Ports: flush/push/pop controls, wr_data in, rd_data (head), count, full, empty.
module arm_fetch_fifo
    import arm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wr_data,
    input  logic         pop,
    output fetch_entry_t rd_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t    mem [DEPTH];
    fetch_entry_t    last_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;

    // When empty, the head keeps showing the last entry it presented.
    assign rd_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (!empty) begin
                last_q <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !flush && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    a_no_push_full : assert property (
        @(posedge clk) disable iff (!reset_n)
        !(push && full && !flush)
    );

endmodule

// File: rtl/arm_fetch_unit.sv
// ARM32 instruction fetch stage: sequential word fetch from a 1-cycle RAM,
// prefetch buffering, valid/ready hand-off to decode, and branch redirect.
// Ports: clk, reset_n; mem_req/mem_addr/mem_rdata to RAM;
// redirect_valid/redirect_pc from execute; ins_valid/ins/ins_pc/ins_ready to decode.
module arm_fetch_unit
    import arm_pkg::*;
#(
    parameter  int              RAM_SIZE   = 4096,
    parameter  int              FIFO_DEPTH = 4,
    parameter  logic [ARCH-1:0] RESET_PC   = '0,
    localparam int              AW         = $clog2(RAM_SIZE),
    localparam int              CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic [ARCH-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [ARCH-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [ARCH-1:0] ins,
    output logic [ARCH-1:0] ins_pc,
    input  logic            ins_ready
);

    logic [ARCH-1:0] fetch_pc;
    logic [ARCH-1:0] tag_pc;
    logic            inflight;
    logic            discard;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   count;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    // Credit counts buffered plus in-flight words; a same-cycle pop
    // does not free a slot until the next cycle.
    assign mem_req = reset_n && !redirect_valid && !fifo_full
                  && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));

    assign mem_addr  = fetch_pc[AW+1:2];
    assign push      = inflight && !discard;
    assign pop       = ins_valid && ins_ready;
    assign wr_entry  = '{ins: mem_rdata, pc: tag_pc};
    assign ins_valid = !fifo_empty;
    assign ins       = head.ins;
    assign ins_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= mem_req;
            discard  <= redirect_valid;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ARCH'(WORD_BYTES - 1);
            end else if (mem_req) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ARCH'(WORD_BYTES);
            end
        end
    end

    arm_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: directed latency/redirect/wrap/reset steps
// followed by random ready/redirect traffic checked by a stream scoreboard.
module tb_arm_fetch_unit;

    localparam int AW = 12;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          ins_valid;
    logic [31:0]   ins;
    logic [31:0]   ins_pc;
    logic          ins_ready;

    logic [31:0] ram [4096];
    logic [31:0] exp_pc;
    int          checks   = 0;
    int          failures = 0;
    int          reqs     = 0;

    always #5 clk = ~clk;

    arm_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= ram[mem_addr];
    end

    function automatic logic [31:0] ram_at(input logic [31:0] pc);
        return ram[pc[AW+1:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Stream model: after reset or a redirect, decode must see the
    // consecutive words starting at the new word-aligned address.
    task automatic observe();
        if (mem_req) reqs++;
        if (!reset_n) begin
            exp_pc = RESET_PC;
        end else if (redirect_valid) begin
            chk("req_in_redirect", 32'(mem_req), 32'd0);
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (ins_valid && ins_ready) begin
            chk("pop_pc", ins_pc, exp_pc);
            chk("pop_ins", ins, ram_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic rdy);
        reset_n = 1'b0;
        ins_ready = rdy;
        redirect_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hE3A0_0000 + i;
        exp_pc = RESET_PC;
        reset_n = 1'b0;
        ins_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        #1;

        // Reset state
        ticks(2);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", ins_pc, 32'd0);

        // Streaming: first instruction two cycles after release
        reset_n = 1'b1;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        tick();
        chk("lat_valid_t1", 32'(ins_valid), 32'd0);
        tick();
        chk("lat_valid_t2", 32'(ins_valid), 32'd1);
        chk("first_ins", ins, 32'hE3A0_0000);
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", 32'(ins_valid), 32'd1);
            chk("stream_pc", ins_pc, 32'(k * 4));
            tick();
        end

        // Decode stall fills the buffer with exactly four requests
        do_reset(1'b0);
        reqs = 0;
        ticks(10);
        chk("stall_reqs", 32'(reqs), 32'd4);
        chk("stall_req_off", 32'(mem_req), 32'd0);
        chk("stall_head_ins", ins, 32'hE3A0_0000);
        chk("stall_head_pc", ins_pc, 32'd0);
        ins_ready = 1'b1;
        ticks(4);
        chk("resume_pc16", ins_pc, 32'd16);
        chk("resume_valid", 32'(ins_valid), 32'd1);

        // Redirect with three buffered entries and one in flight
        do_reset(1'b0);
        ticks(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("redir_req_off", 32'(mem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        ins_ready = 1'b1;
        #1;
        chk("redir_t1_valid", 32'(ins_valid), 32'd0);
        chk("redir_t1_req", 32'(mem_req), 32'd1);
        tick();
        chk("redir_t2_valid", 32'(ins_valid), 32'd0);
        tick();
        chk("redir_t3_valid", 32'(ins_valid), 32'd1);
        chk("redir_t3_pc", ins_pc, 32'h40);

        // Redirect coinciding with a pop, misaligned target
        ticks(6);
        chk("pop_redir_pre", 32'(ins_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("pop_redir_flush", 32'(ins_valid), 32'd0);
        ticks(2);
        chk("misalign_pc", ins_pc, 32'h40);

        // Back-to-back redirects: last one wins
        ticks(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_pc = 32'hC0;
        tick();
        redirect_valid = 1'b0;
        ticks(2);
        chk("b2b_pc", ins_pc, 32'hC0);
        ticks(4);

        // RAM index wrap and 32-bit address wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'h3FFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_hi", 32'(mem_addr), 32'hFFF);
        tick();
        chk("wrap_addr_0", 32'(mem_addr), 32'd0);
        tick();
        chk("wrap_pc_3ffc", ins_pc, 32'h3FFC);
        tick();
        chk("wrap_pc_4000", ins_pc, 32'h4000);
        chk("wrap_ins_4000", ins, 32'hE3A0_0000);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        ticks(2);
        chk("wrap_pc_top", ins_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc_zero", ins_pc, 32'h0);

        // Reset pulse with a full buffer
        ins_ready = 1'b0;
        ticks(8);
        chk("full_req_off", 32'(mem_req), 32'd0);
        reset_n = 1'b0;
        ins_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        #1;
        chk("rstpulse_valid", 32'(ins_valid), 32'd0);
        ticks(2);
        chk("rstpulse_restart", ins_pc, RESET_PC);
        chk("rstpulse_valid2", 32'(ins_valid), 32'd1);

        // Random ready and redirect traffic
        for (int n = 0; n < 600; n++) begin
            ins_ready = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc = $urandom();
            if (redirect_valid && $urandom_range(1) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            tick();
        end
        redirect_valid = 1'b0;
        ins_ready = 1'b1;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
